unidade_controle_treino: RTL and testbench

Moore control unit that sequences the FPGAudio piano training datapath. Each round it replays the stored melody prefix on LEDs and buzzer, then waits for the player to repeat it note by note. Every key press is checked for pitch and, optionally, rhythm against the metronome. The block drives every control input of the datapath and consumes its condition outputs; it contains no datapath arithmetic itself.

---
 rtl/unidade_controle_treino.sv | 207 ++++++++++++++++++++
 tb/tb_unidade_controle_treino.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_treino.sv
// Moore control unit sequencing the FPGAudio piano training datapath.
// Optional rhythm check enabled by defining TEMPO_CHECK_EN.
module unidade_controle_treino (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       bpm_sel,
  input  logic       nota_feita,
  input  logic       nota_correta,
  input  logic       tempo_correto,
  input  logic       fimTF,
  input  logic       fimTempo,
  input  logic       enderecoIgualRodada,
  input  logic       fimCR,
  output logic       zeraR,
  output logic       registraR,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraCR,
  output logic       contaCR,
  output logic       zeraTempo,
  output logic       contaTempo,
  output logic       zeraTF,
  output logic       contaTF,
  output logic       zeraMetro,
  output logic       contaMetro,
  output logic       leds_mem,
  output logic       ativa_leds,
  output logic       toca,
  output logic       gravaM,
  output logic       metro_120BPM,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    StInicial       = 4'h0,
    StPreparacao    = 4'h1,
    StIniciaRodada  = 4'h2,
    StMostra        = 4'h3,
    StProximaMostra = 4'h4,
    StPreparaJogada = 4'h5,
    StEspera        = 4'h6,
    StRegistra      = 4'h7,
    StFeedback      = 4'h8,
    StCompara       = 4'h9,
    StProximaJogada = 4'hA,
    StProximaRodada = 4'hB,
    StFimAcerto     = 4'hC,
    StFimErro       = 4'hD,
    StFimTimeout    = 4'hE,
    StInvalido      = 4'hF
  } estado_e;

  estado_e estado_q, estado_d;
  logic    metro_q, metro_d;
  logic    ok;

`ifdef TEMPO_CHECK_EN
  assign ok = nota_correta & tempo_correto;
`else
  assign ok = nota_correta;
  logic unused_tempo_correto;
  assign unused_tempo_correto = tempo_correto;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= StInicial;
      metro_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      metro_q  <= metro_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    metro_d  = metro_q;
    case (estado_q)
      StInicial:       if (iniciar) estado_d = StPreparacao;
      StPreparacao: begin
        metro_d  = bpm_sel;
        estado_d = StIniciaRodada;
      end
      StIniciaRodada:  estado_d = StMostra;
      StMostra: begin
        if (fimTF) estado_d = enderecoIgualRodada ? StPreparaJogada : StProximaMostra;
      end
      StProximaMostra: estado_d = StMostra;
      StPreparaJogada: estado_d = StEspera;
      StEspera: begin
        // A press beats a simultaneous timeout.
        if (nota_feita)    estado_d = StRegistra;
        else if (fimTempo) estado_d = StFimTimeout;
      end
      StRegistra:      estado_d = StFeedback;
      StFeedback:      if (fimTF && !nota_feita) estado_d = StCompara;
      StCompara: begin
        if (!ok)                             estado_d = StFimErro;
        else if (enderecoIgualRodada && fimCR) estado_d = StFimAcerto;
        else if (enderecoIgualRodada)        estado_d = StProximaRodada;
        else                                 estado_d = StProximaJogada;
      end
      StProximaJogada: estado_d = StEspera;
      StProximaRodada: estado_d = StIniciaRodada;
      StFimAcerto, StFimErro, StFimTimeout: if (iniciar) estado_d = StPreparacao;
      default:         estado_d = StInicial;
    endcase
  end

  // Moore outputs: decoded from the state register only.
  always_comb begin
    zeraR      = 1'b0;
    registraR  = 1'b0;
    zeraC      = 1'b0;
    contaC     = 1'b0;
    zeraCR     = 1'b0;
    contaCR    = 1'b0;
    zeraTempo  = 1'b0;
    contaTempo = 1'b0;
    zeraTF     = 1'b0;
    contaTF    = 1'b0;
    zeraMetro  = 1'b0;
    contaMetro = 1'b0;
    leds_mem   = 1'b0;
    ativa_leds = 1'b0;
    toca       = 1'b0;
    pronto     = 1'b0;
    acertou    = 1'b0;
    errou      = 1'b0;
    timeout    = 1'b0;
    case (estado_q)
      StPreparacao: begin
        zeraCR    = 1'b1;
        zeraC     = 1'b1;
        zeraR     = 1'b1;
        zeraTF    = 1'b1;
        zeraTempo = 1'b1;
        zeraMetro = 1'b1;
      end
      StIniciaRodada: begin
        zeraC  = 1'b1;
        zeraTF = 1'b1;
      end
      StMostra: begin
        leds_mem   = 1'b1;
        ativa_leds = 1'b1;
        toca       = 1'b1;
        contaTF    = 1'b1;
      end
      StProximaMostra: begin
        contaC = 1'b1;
        zeraTF = 1'b1;
      end
      StPreparaJogada: begin
        zeraC     = 1'b1;
        zeraR     = 1'b1;
        zeraTF    = 1'b1;
        zeraTempo = 1'b1;
        zeraMetro = 1'b1;
      end
      StEspera: begin
        registraR  = 1'b1;
        contaTempo = 1'b1;
        contaMetro = 1'b1;
      end
      StRegistra: begin
        registraR  = 1'b1;
        contaMetro = 1'b1;
      end
      StFeedback: begin
        ativa_leds = 1'b1;
        toca       = 1'b1;
        contaTF    = 1'b1;
      end
      StProximaJogada: begin
        contaC    = 1'b1;
        zeraTF    = 1'b1;
        zeraTempo = 1'b1;
        zeraMetro = 1'b1;
      end
      StProximaRodada: contaCR = 1'b1;
      StFimAcerto: begin
        pronto  = 1'b1;
        acertou = 1'b1;
      end
      StFimErro: begin
        pronto = 1'b1;
        errou  = 1'b1;
      end
      StFimTimeout: begin
        pronto  = 1'b1;
        timeout = 1'b1;
      end
      default: ;
    endcase
  end

  assign gravaM       = 1'b0;
  assign metro_120BPM = metro_q;
  assign db_estado    = estado_q;

endmodule

// File: tb/tb_unidade_controle_treino.sv
// Self-checking bench for unidade_controle_treino: directed vector table, reset
// corner case, and randomized stimulus against a rule-level reference model.
module tb_unidade_controle_treino;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic iniciar = 1'b0, bpm_sel = 1'b0, nota_feita = 1'b0, nota_correta = 1'b0;
  logic tempo_correto = 1'b0, fimTF = 1'b0, fimTempo = 1'b0;
  logic enderecoIgualRodada = 1'b0, fimCR = 1'b0;
  logic zeraR, registraR, zeraC, contaC, zeraCR, contaCR, zeraTempo, contaTempo;
  logic zeraTF, contaTF, zeraMetro, contaMetro, leds_mem, ativa_leds, toca, gravaM;
  logic metro_120BPM, pronto, acertou, errou, timeout;
  logic [3:0] db_estado;
  logic [19:0] outs;

  always #5 clock = ~clock;

  unidade_controle_treino dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .bpm_sel(bpm_sel),
    .nota_feita(nota_feita), .nota_correta(nota_correta), .tempo_correto(tempo_correto),
    .fimTF(fimTF), .fimTempo(fimTempo), .enderecoIgualRodada(enderecoIgualRodada),
    .fimCR(fimCR), .zeraR(zeraR), .registraR(registraR), .zeraC(zeraC), .contaC(contaC),
    .zeraCR(zeraCR), .contaCR(contaCR), .zeraTempo(zeraTempo), .contaTempo(contaTempo),
    .zeraTF(zeraTF), .contaTF(contaTF), .zeraMetro(zeraMetro), .contaMetro(contaMetro),
    .leds_mem(leds_mem), .ativa_leds(ativa_leds), .toca(toca), .gravaM(gravaM),
    .metro_120BPM(metro_120BPM), .pronto(pronto), .acertou(acertou), .errou(errou),
    .timeout(timeout), .db_estado(db_estado)
  );

  assign outs = {zeraR, registraR, zeraC, contaC, zeraCR, contaCR, zeraTempo, contaTempo,
                 zeraTF, contaTF, zeraMetro, contaMetro, leds_mem, ativa_leds, toca, gravaM,
                 pronto, acertou, errou, timeout};

  localparam int PZeraR = 19, PRegistraR = 18, PZeraC = 17, PContaC = 16, PZeraCR = 15;
  localparam int PContaCR = 14, PZeraTempo = 13, PContaTempo = 12, PZeraTF = 11;
  localparam int PContaTF = 10, PZeraMetro = 9, PContaMetro = 8, PLedsMem = 7;
  localparam int PAtivaLeds = 6, PToca = 5, PPronto = 3, PAcertou = 2, PErrou = 1;
  localparam int PTimeout = 0;
`ifdef TEMPO_CHECK_EN
  localparam bit TempoEn = 1'b1;
`else
  localparam bit TempoEn = 1'b0;
`endif

  typedef struct {
    logic ini, bpm, nf, nc, tc, ftf, ftp, eir, fcr;
    int   exp;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  logic [19:0] exp_mask [16];
  int          m_state = 0;
  logic        m_metro = 1'b0;
  vec_t        vecs[$];

  function automatic logic [19:0] b(input int p);
    return 20'(1) << p;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference game rules: where the controller goes from each step.
  function automatic int next_state(input int s, input vec_t v);
    bit ok;
    ok = v.nc && (!TempoEn || v.tc);
    case (s)
      0:       return v.ini ? 1 : 0;
      1:       return 2;
      2:       return 3;
      3:       return !v.ftf ? 3 : (v.eir ? 5 : 4);
      4:       return 3;
      5:       return 6;
      6:       return v.nf ? 7 : (v.ftp ? 14 : 6);
      7:       return 8;
      8:       return (v.ftf && !v.nf) ? 9 : 8;
      9:       return !ok ? 13 : (v.eir && v.fcr) ? 12 : v.eir ? 11 : 10;
      10:      return 6;
      11:      return 2;
      12, 13, 14: return v.ini ? 1 : s;
      default: return 0;
    endcase
  endfunction

  task automatic apply(input vec_t v, input string name);
    iniciar = v.ini; bpm_sel = v.bpm; nota_feita = v.nf; nota_correta = v.nc;
    tempo_correto = v.tc; fimTF = v.ftf; fimTempo = v.ftp;
    enderecoIgualRodada = v.eir; fimCR = v.fcr;
    if (m_state == 1) m_metro = v.bpm;
    @(posedge clock);
    #1;
    check({name, " estado"}, 32'(db_estado), 32'(v.exp));
    check({name, " saidas"}, 32'(outs), 32'(exp_mask[v.exp[3:0]]));
    check({name, " metro"}, 32'(metro_120BPM), 32'(m_metro));
    m_state = v.exp;
  endtask

  function automatic vec_t mk(input logic ini, nf, nc, tc, ftf, ftp, eir, fcr, input int e);
    vec_t v;
    v.ini = ini; v.bpm = 1'b1; v.nf = nf; v.nc = nc; v.tc = tc; v.ftf = ftf;
    v.ftp = ftp; v.eir = eir; v.fcr = fcr; v.exp = e;
    return v;
  endfunction

  task automatic check_reset_outputs(input string name);
    check({name, " estado"}, 32'(db_estado), 32'd0);
    check({name, " saidas"}, 32'(outs), 32'd0);
    check({name, " metro"}, 32'(metro_120BPM), 32'd0);
  endtask

  initial begin
    foreach (exp_mask[i]) exp_mask[i] = '0;
    exp_mask[1]  = b(PZeraCR) | b(PZeraC) | b(PZeraR) | b(PZeraTF) | b(PZeraTempo) | b(PZeraMetro);
    exp_mask[2]  = b(PZeraC) | b(PZeraTF);
    exp_mask[3]  = b(PLedsMem) | b(PAtivaLeds) | b(PToca) | b(PContaTF);
    exp_mask[4]  = b(PContaC) | b(PZeraTF);
    exp_mask[5]  = b(PZeraC) | b(PZeraR) | b(PZeraTF) | b(PZeraTempo) | b(PZeraMetro);
    exp_mask[6]  = b(PRegistraR) | b(PContaTempo) | b(PContaMetro);
    exp_mask[7]  = b(PRegistraR) | b(PContaMetro);
    exp_mask[8]  = b(PAtivaLeds) | b(PToca) | b(PContaTF);
    exp_mask[10] = b(PContaC) | b(PZeraTF) | b(PZeraTempo) | b(PZeraMetro);
    exp_mask[11] = b(PContaCR);
    exp_mask[12] = b(PPronto) | b(PAcertou);
    exp_mask[13] = b(PPronto) | b(PErrou);
    exp_mask[14] = b(PPronto) | b(PTimeout);

    #12;
    check_reset_outputs("reset inicial");
    reset = 1'b1;

    // Walk into feedback with the key held, then pull reset between edges.
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 1), "rf ini");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 2), "rf rodada");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 3), "rf mostra");
    apply(mk(0, 0, 0, 0, 1, 0, 1, 0, 5), "rf prepara");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 6), "rf espera");
    apply(mk(0, 1, 0, 0, 0, 0, 0, 0, 7), "rf registra");
    apply(mk(0, 1, 0, 0, 0, 0, 0, 0, 8), "rf feedback");
    #2 reset = 1'b0;
    #1 check_reset_outputs("reset async");
    m_state = 0; m_metro = 1'b0;
    #1 reset = 1'b1;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), "pos reset");

    // ini nf nc tc ftf ftp eir fcr -> estado
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 3));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 4));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 5));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 6));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 7));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 8));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 8));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 8));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 9));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 11));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 5));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 6));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 7));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 8));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 9));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 10));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 6));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 7));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 8));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 9));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 13));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 13));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 5));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 6));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 14));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 14));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 3));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 5));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 6));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 7));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 8));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 9));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, TempoEn ? 13 : 12));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 5));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 6));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 7));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 8));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 9));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, TempoEn ? 13 : 10));

    foreach (vecs[i]) apply(vecs[i], $sformatf("vetor %0d", i));

    // Randomized play against the reference rules, with occasional async resets.
    for (int n = 0; n < 4000; n++) begin
      vec_t v;
      v.ini = ($urandom_range(0, 3) == 0);
      v.bpm = 1'($urandom_range(0, 1));
      v.nf  = ($urandom_range(0, 2) == 0);
      v.nc  = ($urandom_range(0, 3) != 0);
      v.tc  = ($urandom_range(0, 3) != 0);
      v.ftf = ($urandom_range(0, 1) == 0);
      v.ftp = ($urandom_range(0, 7) == 0);
      v.eir = ($urandom_range(0, 2) == 0);
      v.fcr = ($urandom_range(0, 2) == 0);
      v.exp = next_state(m_state, v);
      apply(v, $sformatf("aleatorio %0d", n));
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b0;
        #1 check_reset_outputs("reset aleatorio");
        m_state = 0; m_metro = 1'b0;
        reset = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
